// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and default constants for the UART transmit scheduler.
// The scheduler and its round-robin arbiter both import this package.
package uart_tx_scheduler_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } uart_sched_state_t;

  localparam int UART_MAX_BYTES  = 32;
  localparam int UART_GAP_CYCLES = 16;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant wins,
// wrapping modulo N, so the most recently served requester ranks lowest.
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  assign any_req = |req;

  if (N == 1) begin : g_single
    assign grant_idx = '0;
  end else begin : g_multi
    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
      int unsigned k;
      grant_idx = last_grant;
      k = 0;
      for (int i = N; i >= 1; i--) begin
        k = (int'(last_grant) + i) % N;
        if (req[k[IW-1:0]]) grant_idx = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between N_REQ packet sources; a grant is held for a whole
// packet, and an idle gap follows each packet so the far-end receiver can resync.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MAX_BYTES  = UART_MAX_BYTES,
  parameter int GAP_CYCLES = UART_GAP_CYCLES,
  parameter int GID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][7:0]  req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [GID_W-1:0]       grant_id,
  output logic                   len_err,
  output uart_sched_state_t      dbg_state
);

  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(MAX_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  uart_sched_state_t r_state;
  logic [GID_W-1:0]  r_grant;
  logic [BW-1:0]     r_byte_cnt;
  logic [GW-1:0]     r_gap_cnt;
  logic              r_len_err;

  logic [GID_W-1:0]  w_arb_idx;
  logic              w_any_req;
  logic              w_send;
  logic              w_gnt_valid;
  logic              w_gnt_last;
  uart_byte_t        w_gnt_data;
  logic              w_xfer;
  logic              w_at_max;

  rr_arbiter #(.N(N_REQ), .IW(GID_W)) u_arb (
    .req        (req_valid),
    .last_grant (r_grant),
    .grant_idx  (w_arb_idx),
    .any_req    (w_any_req)
  );

  // Handshake: a byte moves on any clock edge where tx_valid & tx_ready are both
  // high; the granted source sees tx_ready as its req_ready, all others see 0.
  assign w_send      = (r_state == SEND);
  assign w_gnt_valid = req_valid[r_grant];
  assign w_gnt_last  = req_last[r_grant];
  assign w_gnt_data  = req_data[r_grant];
  assign w_xfer      = tx_valid & tx_ready;
  assign w_at_max    = (r_byte_cnt == BYTE_LAST);

  assign tx_valid  = w_send & w_gnt_valid;
  assign tx_data   = w_send ? w_gnt_data : 8'h00;
  assign busy      = (r_state != IDLE);
  assign grant_id  = r_grant;
  assign len_err   = r_len_err;
  assign dbg_state = r_state;

  always_comb begin
    req_ready = '0;
    if (w_send) req_ready[r_grant] = tx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= GID_W'(N_REQ - 1);
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_arb_idx;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_xfer) begin
            // Release on last, or force it at the byte limit; last on the limit byte is normal.
            if (w_gnt_last || w_at_max) begin
              r_byte_cnt <= '0;
              r_len_err  <= !w_gnt_last;
              r_state    <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: three instances (default, MAX_BYTES=4,
// MAX_BYTES=4 with no gap) share stimulus; one is selected per test.
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      req_valid;
  logic [N-1:0][7:0] req_data;
  logic [N-1:0]      req_last;
  logic              tx_ready;

  logic [N-1:0]      rdy  [3];
  logic [7:0]        txd  [3];
  logic              txv  [3];
  logic              bsy  [3];
  logic [1:0]        gid  [3];
  logic              lerr [3];
  uart_sched_state_t st   [3];

  uart_tx_scheduler #(.N_REQ(4), .MAX_BYTES(32), .GAP_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
    .tx_ready(tx_ready), .busy(bsy[0]), .grant_id(gid[0]), .len_err(lerr[0]),
    .dbg_state(st[0])
  );

  uart_tx_scheduler #(.N_REQ(4), .MAX_BYTES(4), .GAP_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
    .tx_ready(tx_ready), .busy(bsy[1]), .grant_id(gid[1]), .len_err(lerr[1]),
    .dbg_state(st[1])
  );

  uart_tx_scheduler #(.N_REQ(4), .MAX_BYTES(4), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[2]), .tx_data(txd[2]), .tx_valid(txv[2]),
    .tx_ready(tx_ready), .busy(bsy[2]), .grant_id(gid[2]), .len_err(lerr[2]),
    .dbg_state(st[2])
  );

  // ---------------- bench state ----------------
  logic [8:0] src_q [N][$];   // {last, byte} per requester
  logic [9:0] exp_q [$];      // {requester, byte} in expected tx order
  logic [N-1:0] stall;
  int sel;
  bit mon_en;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic refresh();
    logic [8:0] hd;
    for (int r = 0; r < N; r++) begin
      hd = (src_q[r].size() != 0) ? src_q[r][0] : 9'h000;
      req_valid[r] = (src_q[r].size() != 0) && !stall[r];
      req_data[r]  = hd[7:0];
      req_last[r]  = hd[8];
    end
  endtask

  always @(posedge clk) begin
    for (int r = 0; r < N; r++)
      if (req_valid[r] && rdy[sel][r]) void'(src_q[r].pop_front());
    #1;
    refresh();
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input int s);
    rst_n  = 1'b0;
    sel    = s;
    mon_en = 1'b0;
    tx_ready = 1'b1;
    stall  = '0;
    for (int r = 0; r < N; r++) src_q[r].delete();
    exp_q.delete();
    refresh();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic last);
    src_q[r].push_back({last, b});
    exp_q.push_back({2'(r), b});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [9:0] mon_e;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (!tx_ready) begin
        check("req_ready_idle", rdy[sel], 0);
      end else if (txv[sel]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_data", txd[sel], mon_e[7:0]);
          check("grant_id", gid[sel], mon_e[9:8]);
          check("req_ready_onehot", rdy[sel], 4'b0001 << mon_e[9:8]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    sel = 0;
    stall = '0;
    tx_ready = 1'b0;
    refresh();

    // 1: reset values, then reset asserted mid-SEND
    do_reset(0);
    check("rst_grant_id", gid[0], 3);
    check("rst_tx_valid", txv[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_len_err", lerr[0], 0);
    check("rst_tx_data", txd[0], 0);
    check("rst_req_ready", rdy[0], 0);
    check("rst_state", st[0], IDLE);
    tx_ready = 1'b0;
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b1, 8'h22});
    refresh();
    step(1);
    check("t1_send_busy", bsy[0], 1);
    check("t1_send_valid", txv[0], 1);
    tx_ready = 1'b1;
    #1;
    check("t1_send_ready", rdy[0], 4'b0001);
    rst_n = 1'b0;
    #1;
    check("t1_midrst_valid", txv[0], 0);
    check("t1_midrst_busy", bsy[0], 0);
    check("t1_midrst_ready", rdy[0], 0);
    do_reset(0);
    check("t1_post_grant_id", gid[0], 3);

    // 2: single packet, latency, exact 16-cycle gap
    do_reset(0);
    mon_en = 1'b1;
    push(0, 8'hA5, 1'b0);
    push(0, 8'h5A, 1'b0);
    push(0, 8'hFF, 1'b1);
    refresh();
    #1;
    check("t2_valid_same_cycle", txv[0], 0);
    step(1);
    check("t2_valid_latency1", txv[0], 1);
    step(3);
    check("t2_state_gap", st[0], GAP);
    check("t2_len_err", lerr[0], 0);
    for (int i = 0; i < 16; i++) begin
      check("t2_gap_busy", bsy[0], 1);
      check("t2_gap_valid", txv[0], 0);
      step(1);
    end
    check("t2_idle_busy", bsy[0], 0);
    check("t2_drained", exp_q.size(), 0);

    // 3: fairness, all four requesting 2-byte packets, req0 has a second packet
    do_reset(0);
    mon_en = 1'b1;
    for (int r = 0; r < N; r++) begin
      push(r, 8'(r * 16), 1'b0);
      push(r, 8'(r * 16 + 1), 1'b1);
    end
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    refresh();
    wait_drain("t3_drained", 300);

    // 4: backpressure with a mid-packet valid stall and a competing requester
    do_reset(0);
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) push(2, 8'(8'hC0 + k), k == 5);
    push(3, 8'hD0, 1'b0);
    push(3, 8'hD1, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      tx_ready = i[0];
      stall[2] = (i >= 4 && i < 7);
      refresh();
      step(1);
    end
    check("t4_drained", exp_q.size(), 0);
    tx_ready = 1'b1;
    stall = '0;

    // 5: overlong packet forces release at MAX_BYTES=4, next grant to req2
    do_reset(1);
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) push(1, 8'(8'h10 + k), 1'b0);
    push(2, 8'h20, 1'b1);
    for (int k = 4; k < 6; k++) push(1, 8'(8'h10 + k), 1'b0);
    refresh();
    step(1);
    check("t5_grant_req1", gid[1], 1);
    step(3);
    check("t5_len_err_early", lerr[1], 0);
    step(1);
    check("t5_len_err_pulse", lerr[1], 1);
    check("t5_state_gap", st[1], GAP);
    check("t5_gap_valid", txv[1], 0);
    step(1);
    check("t5_len_err_once", lerr[1], 0);
    wait_drain("t5_drained", 150);

    // 6: last on the 4th byte is a normal release; no gap means immediate re-grant
    do_reset(2);
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 8'(8'h30 + k), k == 3);
    push(1, 8'h40, 1'b0);
    push(1, 8'h41, 1'b1);
    refresh();
    step(4);
    check("t6_len_err_early", lerr[2], 0);
    step(1);
    check("t6_len_err_normal", lerr[2], 0);
    check("t6_idle_busy", bsy[2], 0);
    step(1);
    check("t6_regrant_id", gid[2], 1);
    check("t6_regrant_valid", txv[2], 1);
    wait_drain("t6_drained", 50);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
